// File: rtl/legv8_pkg.sv
// legv8_pkg: LEGv8 opcode constants, ALU control encodings and immediate formats.
package legv8_pkg;
  typedef enum logic [2:0] {IMM_NONE, IMM_I12, IMM_D9, IMM_CB19, IMM_B26, IMM_MOVZ} imm_fmt_t;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [3:0]  ALU_AND  = 4'b0000;
  localparam logic [3:0]  ALU_ORR  = 4'b0001;
  localparam logic [3:0]  ALU_ADD  = 4'b0010;
  localparam logic [3:0]  ALU_SUB  = 4'b0110;
  localparam logic [3:0]  ALU_PASS = 4'b0111;
  localparam logic [4:0]  LINK_REG = 5'd30;
endpackage

// File: rtl/legv8_imm_ext.sv
// legv8_imm_ext: builds the 32-bit immediate from the low 26 instruction bits for a given format.
module legv8_imm_ext
  import legv8_pkg::*;
(
  input  imm_fmt_t    i_fmt,
  input  logic [25:0] i_field,
  output logic [31:0] o_imm
);
  logic [1:0] w_hw;
  logic [31:0] w_movz;
  assign w_hw = i_field[22:21];
  // only the two lower half-word positions fit a 32-bit result
  assign w_movz = w_hw == 2'd0 ? {16'd0, i_field[20:5]} :
                  w_hw == 2'd1 ? {i_field[20:5], 16'd0} : 32'd0;
  assign o_imm = i_fmt == IMM_I12  ? {20'd0, i_field[21:10]} :
                 i_fmt == IMM_D9   ? {{23{i_field[20]}}, i_field[20:12]} :
                 i_fmt == IMM_CB19 ? {{13{i_field[23]}}, i_field[23:5]} :
                 i_fmt == IMM_B26  ? {{6{i_field[25]}}, i_field[25:0]} :
                 i_fmt == IMM_MOVZ ? w_movz : 32'd0;
endmodule

// File: rtl/legv8_decoder.sv
// legv8_decoder: registered LEGv8 decoder producing datapath controls, ALU op, register indices and immediate.
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        reg2loc,
  output logic        ub,
  output logic        cb,
  output logic        memr,
  output logic        memw,
  output logic        mem2r,
  output logic        ALUsrc,
  output logic        regw,
  output logic [3:0]  ALUctrl,
  output logic [4:0]  reg1,
  output logic [4:0]  reg2,
  output logic [4:0]  wreg,
  output logic [31:0] imm
);
  logic [10:0] w_op11;
  logic [9:0] w_op10;
  logic w_reg2loc, w_ub, w_cb, w_memr, w_memw, w_mem2r, w_alusrc, w_regw;
  logic [3:0] w_alu;
  logic [4:0] w_wreg;
  logic [31:0] w_imm;
  imm_fmt_t w_fmt;
  assign w_op11 = instruction[31:21];
  assign w_op10 = instruction[31:22];
  legv8_imm_ext u_imm_ext (
    .i_fmt  (w_fmt),
    .i_field(instruction[25:0]),
    .o_imm  (w_imm)
  );
  // first matching opcode wins; unmatched words leave every control bit low
  always_comb begin
    {w_reg2loc, w_ub, w_cb, w_memr, w_memw, w_mem2r, w_alusrc, w_regw} = '0;
    w_alu = ALU_ADD;
    w_wreg = instruction[4:0];
    w_fmt = IMM_NONE;
    if (w_op11 == OP_ADD || w_op11 == OP_SUB || w_op11 == OP_AND || w_op11 == OP_ORR) begin
      w_regw = 1'b1;
      w_alu = w_op11 == OP_SUB ? ALU_SUB : w_op11 == OP_AND ? ALU_AND :
              w_op11 == OP_ORR ? ALU_ORR : ALU_ADD;
    end else if (w_op10 == OP_ADDI || w_op10 == OP_SUBI || w_op10 == OP_ANDI || w_op10 == OP_ORRI) begin
      w_regw = 1'b1;
      w_alusrc = 1'b1;
      w_fmt = IMM_I12;
      w_alu = w_op10 == OP_SUBI ? ALU_SUB : w_op10 == OP_ANDI ? ALU_AND :
              w_op10 == OP_ORRI ? ALU_ORR : ALU_ADD;
    end else if (w_op11 == OP_LDUR) begin
      {w_memr, w_mem2r, w_regw, w_alusrc} = 4'b1111;
      w_fmt = IMM_D9;
    end else if (w_op11 == OP_STUR) begin
      {w_memw, w_reg2loc, w_alusrc} = 3'b111;
      w_fmt = IMM_D9;
    end else if (instruction[31:24] == OP_CBZ) begin
      {w_cb, w_reg2loc} = 2'b11;
      w_alu = ALU_PASS;
      w_fmt = IMM_CB19;
    end else if (instruction[31:26] == OP_B) begin
      w_ub = 1'b1;
      w_fmt = IMM_B26;
    end else if (instruction[31:26] == OP_BL) begin
      {w_ub, w_regw} = 2'b11;
      w_wreg = LINK_REG;
      w_fmt = IMM_B26;
    end else if (instruction[31:23] == OP_MOVZ) begin
      {w_regw, w_alusrc} = 2'b11;
      w_alu = ALU_PASS;
      w_fmt = IMM_MOVZ;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {reg2loc, ub, cb, memr, memw, mem2r, ALUsrc, regw} <= '0;
      ALUctrl <= '0;
      reg1 <= '0;
      reg2 <= '0;
      wreg <= '0;
      imm <= '0;
    end else begin
      {reg2loc, ub, cb, memr, memw, mem2r, ALUsrc, regw} <=
        {w_reg2loc, w_ub, w_cb, w_memr, w_memw, w_mem2r, w_alusrc, w_regw};
      ALUctrl <= w_alu;
      reg1 <= instruction[9:5];
      reg2 <= w_reg2loc ? instruction[4:0] : instruction[20:16];
      wreg <= w_wreg;
      imm <= w_imm;
    end
  end
endmodule

// File: tb/tb_legv8_decoder.sv
// tb_legv8_decoder: directed vectors with hand-decoded expectations for legv8_decoder.
module tb_legv8_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instruction = 32'h8B150289;
  logic reg2loc, ub, cb, memr, memw, mem2r, ALUsrc, regw;
  logic [3:0] ALUctrl;
  logic [4:0] reg1, reg2, wreg;
  logic [31:0] imm;
  int n_chk = 0;
  int n_pass = 0;
  logic [26:0] prev_bundle = '0;
  logic [31:0] prev_imm = '0;
  logic [26:0] w_bundle;
  always #5 clk = ~clk;
  legv8_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .reg2loc(reg2loc), .ub(ub), .cb(cb), .memr(memr), .memw(memw), .mem2r(mem2r),
    .ALUsrc(ALUsrc), .regw(regw), .ALUctrl(ALUctrl),
    .reg1(reg1), .reg2(reg2), .wreg(wreg), .imm(imm)
  );
  assign w_bundle = {reg2loc, ub, cb, memr, memw, mem2r, ALUsrc, regw, ALUctrl, reg1, reg2, wreg};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic vec(input string tag, input logic [31:0] ins, input logic [7:0] c,
                     input logic [3:0] a, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] w, input logic [31:0] im);
    @(negedge clk);
    instruction = ins;
    #1;
    chk({tag, " hold ctl"}, {5'd0, w_bundle}, {5'd0, prev_bundle});
    chk({tag, " hold imm"}, imm, prev_imm);
    @(posedge clk);
    #1;
    chk({tag, " ctl"}, {24'd0, reg2loc, ub, cb, memr, memw, mem2r, ALUsrc, regw}, {24'd0, c});
    chk({tag, " alu"}, {28'd0, ALUctrl}, {28'd0, a});
    chk({tag, " regs"}, {17'd0, reg1, reg2, wreg}, {17'd0, r1, r2, w});
    chk({tag, " imm"}, imm, im);
    prev_bundle = {c, a, r1, r2, w};
    prev_imm = im;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctl", {5'd0, w_bundle}, 32'd0);
    chk("reset imm", imm, 32'd0);
    rst_n = 1'b1;
    vec("add",     32'h8B150289, 8'b00000001, 4'b0010, 5'd20, 5'd21, 5'd9,  32'd0);
    vec("addi",    32'h910006D6, 8'b00000011, 4'b0010, 5'd22, 5'd0,  5'd22, 32'd1);
    vec("ldur",    32'hF8400149, 8'b00010111, 4'b0010, 5'd10, 5'd0,  5'd9,  32'd0);
    vec("ldur neg",32'hF85FF149, 8'b00010111, 4'b0010, 5'd10, 5'd31, 5'd9,  32'hFFFFFFFF);
    vec("stur",    32'hF8008149, 8'b10001010, 4'b0010, 5'd10, 5'd9,  5'd9,  32'd8);
    vec("cbz",     32'hB4000827, 8'b10100000, 4'b0111, 5'd1,  5'd7,  5'd7,  32'd65);
    vec("bl",      32'h97FFFFFB, 8'b01000001, 4'b0010, 5'd31, 5'd31, 5'd30, 32'hFFFFFFFB);
    vec("b",       32'h14000003, 8'b01000000, 4'b0010, 5'd0,  5'd0,  5'd3,  32'd3);
    vec("movz",    32'hD2800143, 8'b00000011, 4'b0111, 5'd10, 5'd0,  5'd3,  32'd10);
    vec("movz hw1",32'hD2A00143, 8'b00000011, 4'b0111, 5'd10, 5'd0,  5'd3,  32'h000A0000);
    vec("movz hw2",32'hD2C00143, 8'b00000011, 4'b0111, 5'd10, 5'd0,  5'd3,  32'd0);
    vec("illegal", 32'h00000000, 8'b00000000, 4'b0010, 5'd0,  5'd0,  5'd0,  32'd0);
    vec("sub",     32'hCB030041, 8'b00000001, 4'b0110, 5'd2,  5'd3,  5'd1,  32'd0);
    vec("and",     32'h8A030041, 8'b00000001, 4'b0000, 5'd2,  5'd3,  5'd1,  32'd0);
    vec("orr",     32'hAA030041, 8'b00000001, 4'b0001, 5'd2,  5'd3,  5'd1,  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst ctl", {5'd0, w_bundle}, 32'd0);
    chk("async rst imm", imm, 32'd0);
    rst_n = 1'b1;
    prev_bundle = '0;
    prev_imm = '0;
    vec("orri",    32'hB23FFC41, 8'b00000011, 4'b0001, 5'd2,  5'd31, 5'd1,  32'h00000FFF);
    vec("subi",    32'hD1000C41, 8'b00000011, 4'b0110, 5'd2,  5'd0,  5'd1,  32'd3);
    vec("andi",    32'h92000C41, 8'b00000011, 4'b0000, 5'd2,  5'd0,  5'd1,  32'd3);
    vec("cbnz",    32'hB5000827, 8'b00000000, 4'b0010, 5'd1,  5'd0,  5'd7,  32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/legv8_decoder.md
Name: legv8_decoder

Overview:
Registered LEGv8 instruction decoder for the single-cycle/pipelined core, sitting between instruction fetch and the register file/ALU/data-memory control. Takes a 32-bit instruction and produces datapath control bits, a 4-bit ALU operation, register indices and a 32-bit extended immediate. All outputs are registered and appear one clock after the instruction is presented.

Parameters:
none (widths fixed: instruction 32, register index 5, immediate 32, ALU control 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instruction  input  32  instruction word to decode
reg2loc  output  1  1 = reg2 sourced from Rt [4:0], 0 = from Rm [20:16]
ub  output  1  unconditional branch (B, BL)
cb  output  1  conditional branch (CBZ)
memr  output  1  data-memory read
memw  output  1  data-memory write
mem2r  output  1  write-back selects memory data
ALUsrc  output  1  ALU operand B = immediate
regw  output  1  register-file write enable
ALUctrl  output  4  ALU op: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
reg1  output  5  read register 1
reg2  output  5  read register 2
wreg  output  5  write register
imm  output  32  extended immediate (word offsets for branches, unscaled)

Behaviour:
- rst_n low (asynchronous): all outputs 0. Reset asserted mid-stream clears outputs immediately; first decode after release happens on the next rising edge.
- Each rising edge: decode `instruction` combinationally, register all outputs. Latency is exactly 1 cycle; no handshake. A new instruction may be applied every cycle.
- Field defaults: reg1 = inst[9:5]; reg2 = reg2loc ? inst[4:0] : inst[20:16]; wreg = inst[4:0]; imm = 0; all control bits 0; ALUctrl = 0010.
- Opcode match, first hit wins:
  - inst[31:21] 10001011000 ADD / 11001011000 SUB / 10001010000 AND / 10101010000 ORR: regw=1, ALUsrc=0, ALUctrl = 0010/0110/0000/0001.
  - inst[31:22] 1001000100 ADDI / 1101000100 SUBI / 1001001000 ANDI / 1011001000 ORRI: regw=1, ALUsrc=1, imm = zero-extended inst[21:10], ALUctrl as the R-type equivalent.
  - inst[31:21] 11111000010 LDUR: memr=1, mem2r=1, regw=1, ALUsrc=1, ALUctrl=0010, imm = sign-extended inst[20:12].
  - inst[31:21] 11111000000 STUR: memw=1, reg2loc=1, ALUsrc=1, ALUctrl=0010, imm = sign-extended inst[20:12].
  - inst[31:24] 10110100 CBZ: cb=1, reg2loc=1, ALUctrl=0111, imm = sign-extended inst[23:5].
  - inst[31:26] 000101 B: ub=1, imm = sign-extended inst[25:0].
  - inst[31:26] 100101 BL: ub=1, regw=1, wreg=30, imm = sign-extended inst[25:0].
  - inst[31:23] 110100101 MOVZ: regw=1, ALUsrc=1, ALUctrl=0111, imm = zero-extended inst[20:5] shifted left by 16 when inst[22:21]=01; hw ≥ 2 yields imm=0.
  - Anything else (including CBNZ, shifts): all control bits 0, imm=0, ALUctrl=0010, register fields per defaults. No side effects.
- Sign extension replicates the field MSB up to bit 31.

Decomposition:
- Shared package legv8_pkg: opcode constants (11/10/9/8/6-bit), ALU control encodings, link-register index 30.
- One combinational sub-module natural: legv8_imm_ext (format select + instruction → 32-bit imm); the top holds the opcode match and output registers.

Test Plan:
- Reset: rst_n=0 while instruction=ADD → all outputs 0; release, next edge decodes.
- ADD X9,X20,X21 (0x8B150289) → reg1=20, reg2=21, wreg=9, regw=1, ALUsrc=0, ALUctrl=0010, imm=0, one cycle later.
- ADDI X22,X22,#1 (0x910006D6) → reg1=22, wreg=22, imm=1, ALUsrc=1, regw=1. LDUR X9,[X10,#0] (0xF8400149) → reg1=10, wreg=9, imm=0, memr=mem2r=regw=ALUsrc=1.
- CBZ X7,#65 (0xB4000827) → cb=1, reg2loc=1, reg2=7, imm=65, ALUctrl=0111, regw=0.
- BL #-5 (0x97FFFFFB) → ub=1, regw=1, wreg=30, imm=0xFFFFFFFB. MOVZ X3,#10 (0xD2800143) → wreg=3, imm=10, ALUsrc=1, regw=1, ALUctrl=0111.
- Illegal 0x00000000, then back-to-back instructions each cycle → controls all 0 for illegal; each output tracks its instruction with exactly 1-cycle lag; rst_n pulse mid-sequence zeroes outputs asynchronously.
